// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, one-cycle synchronous instruction memory interface,
// same-cycle branch predictor lookup, and a small FIFO feeding decode.
module instr_fetch #(
    parameter int               WIDTH    = 31,
    parameter int               INDEX    = 7,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             globalResetN,
    input  logic             commitRedirect,
    input  logic [WIDTH:0]   commitTarget,
    input  logic             earlyMisdirect,
    input  logic             freeze,
    input  logic             predTaken,
    input  logic [WIDTH:0]   predTarget,
    input  logic [INDEX:0]   predGHRIndex,
    input  logic [1:0]       predPHTState,
    input  logic [WIDTH:0]   imemData,
    output logic [WIDTH:0]   imemAddr,
    output logic             imemRead,
    output logic [WIDTH:0]   instruction,
    output logic [WIDTH:0]   instrPC,
    output logic [WIDTH:0]   predictedPCF,
    output logic [INDEX:0]   GHRIndex,
    output logic [1:0]       PHTState,
    output logic             redirect,
    output logic             fetchValid
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    localparam logic [WIDTH:0] PC_STEP = (WIDTH + 1)'(4);
    localparam logic [WIDTH:0] NOP     = (WIDTH + 1)'(32'h0000_0013);

    // Prediction metadata carried along with every fetched word
    typedef struct packed {
        logic [WIDTH:0] pc;
        logic           taken;
        logic [WIDTH:0] target;
        logic [INDEX:0] ghr;
        logic [1:0]     pht;
    } meta_t;

    typedef struct packed {
        logic [WIDTH:0] word;
        meta_t          meta;
    } entry_t;

    logic [WIDTH:0]  fpc_q, fpc_d;
    logic            slotValid_q, slotValid_d;
    meta_t           slotMeta_q, slotMeta_d;
    logic [PTRW-1:0] wrPtr_q, wrPtr_d;
    logic [PTRW-1:0] rdPtr_q, rdPtr_d;
    logic [CNTW-1:0] count_q, count_d;
    entry_t          fifoMem_q [DEPTH];

    entry_t          headEntry;
    entry_t          newEntry;
    logic [CNTW:0]   occupancy;
    logic            emFlush;
    logic            flush;
    logic            issue;
    logic            push;
    logic            pop;

    // Cycle decisions: flush sources, issue gating on total occupancy, FIFO push/pop
    always_comb begin
        headEntry  = fifoMem_q[rdPtr_q];
        fetchValid = (count_q != '0);
        emFlush    = earlyMisdirect & fetchValid;
        flush      = commitRedirect | emFlush;
        occupancy  = {1'b0, count_q} + {{CNTW{1'b0}}, slotValid_q};
        issue      = globalResetN & ~flush & (occupancy < (CNTW + 1)'(DEPTH));
        push       = slotValid_q & ~flush;
        pop        = fetchValid & ~freeze & ~flush;
        newEntry   = '{word: imemData, meta: slotMeta_q};
        imemRead   = issue;
        imemAddr   = fpc_q;
    end

    // Next-state for fetch PC, in-flight slot and FIFO pointers
    always_comb begin
        fpc_d       = fpc_q;
        slotValid_d = issue;
        slotMeta_d  = slotMeta_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;

        if (commitRedirect) begin
            fpc_d = commitTarget;
        end else if (emFlush) begin
            fpc_d = headEntry.meta.pc + PC_STEP;
        end else if (issue) begin
            fpc_d = predTaken ? predTarget : fpc_q + PC_STEP;
        end

        if (issue) begin
            slotMeta_d = '{pc: fpc_q, taken: predTaken, target: predTarget,
                           ghr: predGHRIndex, pht: predPHTState};
        end

        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PTRW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTRW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!globalResetN) begin
            fpc_q       <= RESET_PC;
            slotValid_q <= 1'b0;
            slotMeta_q  <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
        end else begin
            fpc_q       <= fpc_d;
            slotValid_q <= slotValid_d;
            slotMeta_q  <= slotMeta_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (globalResetN && push) begin
            fifoMem_q[wrPtr_q] <= newEntry;
        end
    end

    // Head fields presented to decode, with a NOP bubble when empty
    always_comb begin
        instruction  = NOP;
        instrPC      = '0;
        predictedPCF = '0;
        GHRIndex     = '0;
        PHTState     = '0;
        redirect     = 1'b0;
        if (fetchValid) begin
            instruction  = headEntry.word;
            instrPC      = headEntry.meta.pc;
            predictedPCF = headEntry.meta.taken ? headEntry.meta.target
                                                : headEntry.meta.pc + PC_STEP;
            GHRIndex     = headEntry.meta.ghr;
            PHTState     = headEntry.meta.pht;
            redirect     = headEntry.meta.taken;
        end
    end

endmodule
